// File: rtl/chi_stage.sv
// chi_stage: registered chi step on one NxN plane, valid/ready in and out,
// 2-entry skid buffer so in_ready comes straight from a flop.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    upstream handshake; in_data is the N*N plane
//   out_valid/out_ready  downstream handshake; out_data is the chi result
//   iota_bit             only with CHI_STAGE_IOTA_EN: XORed into bit 0
//
// Optional macro: CHI_STAGE_IOTA_EN
module chi_stage #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*N-1:0] in_data,
`ifdef CHI_STAGE_IOTA_EN
    input  logic           iota_bit,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*N-1:0] out_data
);

    localparam int W = N * N;

    // state bits are {skid_v, main_v}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        BAD   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic [W-1:0]   f_in;
    logic           in_xfer;
    logic           out_xfer;

    function automatic logic [W-1:0] chi(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = '0;
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                r[y*N+x] = a[y*N+x]
                         ^ (~a[y*N+(x+1)%N] & a[y*N+(x+2)%N]);
            end
        end
        return r;
    endfunction

    always_comb begin
        f_in = chi(in_data);
`ifdef CHI_STAGE_IOTA_EN
        f_in[0] = f_in[0] ^ iota_bit;
`endif
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = f_in;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = f_in;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer) begin
                    // downstream stalled: park the new word
                    skid_d  = f_in;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_chi_stage.sv
// tb_chi_stage: directed and random checks of chi_stage against a
// row-rotation model of chi and an in-order word queue.
module tb_chi_stage;

    localparam int N = 5;
    localparam int W = N * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         iota_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int checks;
    int errors;

    logic [W-1:0] q[$];

    chi_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef CHI_STAGE_IOTA_EN
        .iota_bit  (iota_bit),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // chi as row rotations: each row r -> r ^ (~rot1(r) & rot2(r))
    function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                           input logic io);
        logic [W-1:0] res;
        int unsigned  row, s1, s2, m;
        m   = (1 << N) - 1;
        res = '0;
        for (int y = 0; y < N; y++) begin
            row = (int'(d >> (y * N))) & m;
            s1  = ((row >> 1) | (row << (N - 1))) & m;
            s2  = ((row >> 2) | (row << (N - 2))) & m;
            res = res | (W'((row ^ (~s1 & s2)) & m) << (y * N));
        end
`ifdef CHI_STAGE_IOTA_EN
        res[0] = res[0] ^ io;
`else
        if (io) res = res;
`endif
        return res;
    endfunction

    task automatic chk(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // every-cycle compare against the queue model
    always @(negedge clk) begin
        logic can_in;
        logic can_out;
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("mon_out_valid", W'(out_valid), W'(q.size() != 0));
            chk("mon_in_ready", W'(in_ready), W'(q.size() < 2));
            if (out_valid && q.size() > 0)
                chk("mon_out_data", out_data, q[0]);
            can_in  = q.size() < 2;
            can_out = q.size() > 0;
            if (out_ready && can_out) void'(q.pop_front());
            if (in_valid && can_in) q.push_back(model(in_data, iota_bit));
        end
    end

    task automatic send(input logic [W-1:0] d);
        logic acc;
        int   cyc;
        acc      = 1'b0;
        cyc      = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("send_accept", W'(acc), W'(1));
    endtask

    task automatic stream(input int n, input bit tog);
        int acc_n;
        int cyc;
        logic acc;
        acc_n = 0;
        cyc   = 0;
        while (acc_n < n && cyc < 5000) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            out_ready = tog ? ~out_ready : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                acc_n++;
                in_valid = 1'b0;
            end
        end
        chk("stream_count", W'(acc_n), W'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stream_drained", W'(q.size()), W'(0));
    endtask

    logic [W-1:0] vin[4];
    logic [W-1:0] vexp[4];

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        iota_bit  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_data", out_data, W'(0));
        rst_n = 1'b1;

        // single word, one-cycle latency and one-cycle pulse
        @(posedge clk);
        #1;
        send(25'h0000001);
        @(negedge clk);
        chk("single_valid", W'(out_valid), W'(1));
        chk("single_data", out_data, 25'h0000009);
        @(negedge clk);
        chk("single_pulse", W'(out_valid), W'(0));

        vin[0] = 25'h0000002; vexp[0] = 25'h0000012;
        vin[1] = 25'h1FFFFFF; vexp[1] = 25'h1FFFFFF;
        vin[2] = 25'h000001F; vexp[2] = 25'h000001F;
        vin[3] = 25'h0000000; vexp[3] = 25'h0000000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            send(vin[i]);
            @(negedge clk);
            chk("vec_valid", W'(out_valid), W'(1));
            chk("vec_data", out_data, vexp[i]);
        end

        // backpressure fills main then skid
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(25'h1);
        send(25'h2);
        @(negedge clk);
        chk("bp_full_ready", W'(in_ready), W'(0));
        chk("bp_hold_data", out_data, 25'h9);
        @(negedge clk);
        chk("bp_hold_data2", out_data, 25'h9);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", W'(in_ready), W'(0));
        @(negedge clk);
        chk("bp_first", out_data, 25'h9);
        @(negedge clk);
        chk("bp_second", out_data, 25'h12);
        chk("bp_ready_back", W'(in_ready), W'(1));
        @(negedge clk);
        chk("bp_empty", W'(out_valid), W'(0));

        // random traffic, then out_ready toggling every cycle
        @(posedge clk);
        #1;
        stream(100, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stream(20, 1'b1);

        // asynchronous reset while FULL
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(25'h1);
        send(25'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_ready", W'(in_ready), W'(1));
        chk("mid_rst_data", out_data, W'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        send(25'h2);
        @(negedge clk);
        chk("post_rst_data", out_data, 25'h12);

`ifdef CHI_STAGE_IOTA_EN
        @(posedge clk);
        #1;
        iota_bit = 1'b1;
        send(25'h0000001);
        iota_bit = 1'b0;
        @(negedge clk);
        chk("iota_on", out_data, 25'h0000008);
        @(posedge clk);
        #1;
        send(25'h0000001);
        @(negedge clk);
        chk("iota_off", out_data, 25'h0000009);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
